inst_mem_sync: RTL

Parametrised synchronous instruction memory for the CPU fetch stage, replacing the single-cycle combinational ROM. It serves instruction words over a valid/ready fetch handshake with one cycle of read latency and a held response under back-pressure. Out-of-range fetches are flagged rather than silently aliased. An optional loader port rewrites the program image at run time without a resynthesis.

---
 rtl/inst_mem_pkg.sv | 28 ++
 rtl/inst_mem_sync_if.sv | 23 ++
 rtl/inst_mem_rsp_reg.sv | 50 +++++
 rtl/inst_mem_sync.sv | 105 ++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and the power-on program image for the instruction memory.
package inst_mem_pkg;

  localparam int IMG_LEN = 12;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;

  function automatic logic [31:0] default_image(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'h24010001;
      1:       w = 32'h00011100;
      2:       w = 32'h00411821;
      3:       w = 32'h00022082;
      4:       w = 32'h00642823;
      5:       w = 32'hAC250013;
      6:       w = 32'h00A23027;
      7:       w = 32'h00C33825;
      8:       w = 32'h00E64026;
      9:       w = 32'hAC08001C;
      10:      w = 32'h00C7482A;
      11:      w = 32'h08000000;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_mem_sync_if.sv
// Fetch request / response handshake between the fetch stage (master) and memory (slave).
interface inst_mem_sync_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_inst;
  logic              rsp_err;
  logic              rsp_ready;

  modport master (
    output fetch_req, fetch_addr, rsp_ready,
    input  fetch_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  fetch_req, fetch_addr, rsp_ready,
    output fetch_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/inst_mem_rsp_reg.sv
// One-entry response register: holds data under back-pressure, reloads back-to-back when consumed.
module inst_mem_rsp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              free
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // load is only raised by the owner while free is high
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      err_d   = load_err;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign free      = !valid_q || rsp_ready;
endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with 1-cycle fetch latency and range flagging.
// INST_MEM_LOAD_EN builds the run-time loader port and the RUN/DRAIN/LOAD sequencer.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 20
) (
  input  logic               clk,
  input  logic               rst,
  inst_mem_sync_if.slave     bus,
`ifdef INST_MEM_LOAD_EN
  input  logic               load_start,
  input  logic               load_done,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_busy,
`endif
  output logic [15:0]        fetch_cnt
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              rsp_free;
  logic              accept;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;

  assign rd_err = ({1'b0, bus.fetch_addr} >= DEPTH_L);

`ifdef INST_MEM_LOAD_EN
  state_e            state_q, state_d;
  logic              load_busy_q, load_busy_d;
  logic              load_wr;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign bus.fetch_ready = (state_q == RUN) && rsp_free;
  // a coincident load_start wins over the fetch
  assign accept  = bus.fetch_req && bus.fetch_ready && !load_start;
  assign load_wr = (state_q == LOAD) && load_we && ({1'b0, load_addr} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_start) state_d = (bus.rsp_valid && !bus.rsp_ready) ? DRAIN : LOAD;
      DRAIN:   if (bus.rsp_ready) state_d = LOAD;
      LOAD:    if (load_done) state_d = RUN;
      default: state_d = RUN;
    endcase
    load_busy_d = (state_d != RUN);
  end

  always_comb begin
    mem_d = mem_q;
    if (load_wr) mem_d[load_addr] = load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      load_busy_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(default_image(unsigned'(i)));
    end else begin
      state_q     <= state_d;
      load_busy_q <= load_busy_d;
      mem_q       <= mem_d;
    end
  end

  assign load_busy = load_busy_q;
  assign rd_word   = rd_err ? '0 : mem_q[bus.fetch_addr];
`else
  assign bus.fetch_ready = rsp_free;
  assign accept          = bus.fetch_req && bus.fetch_ready;
  assign rd_word         = rd_err ? '0 : DATA_W'(default_image(32'(bus.fetch_addr)));
`endif

  inst_mem_rsp_reg #(.DATA_W(DATA_W)) u_rsp (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (rd_word),
    .load_err  (rd_err),
    .rsp_ready (bus.rsp_ready),
    .rsp_valid (bus.rsp_valid),
    .rsp_data  (bus.rsp_inst),
    .rsp_err   (bus.rsp_err),
    .free      (rsp_free)
  );

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (accept) fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_q <= '0;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
endmodule
